// File: rtl/inst_rom_ctrl.sv
// inst_rom_ctrl: instruction ROM with a fetch FSM and a program-loader write port.
// A fetch request is accepted in IDLE or RESP. After WAIT extra cycles it returns a
// registered instruction with a one-cycle instValid.
// Optional feature: define IROM_ALIGN_CHECK_EN to flag fetches where pc[1:0] != 0.
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   romCe, pc           - fetch request and byte address
//   ldWe, ldAddr, ldData - loader word write (write-first against a same-edge read)
//   inst, instValid     - registered instruction and its one-cycle valid
//   busy                - request waiting; no new request is accepted
//   rangeErr, alignErr  - response error flags, only meaningful with instValid
module inst_rom_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned WAIT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              romCe,
   input  logic [31:0]       pc,
   input  logic              ldWe,
   input  logic [ADDR_W-1:0] ldAddr,
   input  logic [31:0]       ldData,
   output logic [31:0]       inst,
   output logic              instValid,
   output logic              busy,
   output logic              rangeErr,
   output logic              alignErr
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      inst_q, inst_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             range_q, range_d;
   logic             align_q, align_d;

   logic [31:0]      mem [DEPTH];

   logic             accept_c;
   logic             read_c;
   logic [31:0]      rd_pc_c;
   logic [ADDR_W-1:0] rd_idx_c;
   logic             rd_oor_c;
   logic             rd_mis_c;
   logic [31:0]      rd_data_c;

   // On an accepting edge the address comes straight from pc, otherwise from the capture.
   assign rd_pc_c  = accept_c ? pc : pc_q;
   assign rd_idx_c = rd_pc_c[ADDR_W+1:2];
   assign rd_oor_c = (rd_pc_c >> (ADDR_W + 2)) != 32'd0;
   // Write-first: a loader write to the word being read wins.
   assign rd_data_c = (ldWe && (ldAddr == rd_idx_c)) ? ldData : mem[rd_idx_c];

`ifdef IROM_ALIGN_CHECK_EN
   assign rd_mis_c = rd_pc_c[1:0] != 2'b00;
`else
   logic unused_pc_lsb_c;
   assign unused_pc_lsb_c = ^rd_pc_c[1:0];
   assign rd_mis_c        = 1'b0;
`endif

   // Next-state, counter and registered-output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pc_d     = pc_q;
      accept_c = 1'b0;
      read_c   = 1'b0;
      case (state_q)
         S_IDLE, S_RESP: begin
            if (romCe) begin
               accept_c = 1'b1;
               pc_d     = pc;
               if (WAIT == 32'd0) begin
                  state_d = S_RESP;
                  read_c  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LD;
               end
            end else begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            // Dropping romCe while waiting cancels the request.
            if (!romCe) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = S_RESP;
               read_c  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      inst_d  = inst_q;
      valid_d = read_c;
      busy_d  = (state_d == S_WAIT);
      range_d = 1'b0;
      align_d = 1'b0;
      if (read_c) begin
         range_d = rd_oor_c;
         align_d = rd_mis_c;
         inst_d  = (rd_oor_c || rd_mis_c) ? 32'h0 : rd_data_c;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pc_q    <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         range_q <= 1'b0;
         align_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         range_q <= range_d;
         align_q <= align_d;
      end
   end

   // Loader writes; contents survive reset, writes are blocked while reset is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
      end else if (ldWe) begin
         mem[ldAddr] <= ldData;
      end
   end

   assign inst      = inst_q;
   assign instValid = valid_q;
   assign busy      = busy_q;
   assign rangeErr  = range_q;
   assign alignErr  = align_q;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Directed bench for inst_rom_ctrl: three instances with WAIT=0, 3 and 2 share the
// clock, reset and loader port; each has its own fetch inputs.
module tb_inst_rom_ctrl;

   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              ldWe;
   logic [ADDR_W-1:0] ldAddr;
   logic [31:0]       ldData;

   logic        romCe0, romCe3, romCe2;
   logic [31:0] pc0, pc3, pc2;
   logic [31:0] inst0, inst3, inst2;
   logic        valid0, valid3, valid2;
   logic        busy0, busy3, busy2;
   logic        rerr0, rerr3, rerr2;
   logic        aerr0, aerr3, aerr2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_rom_ctrl #(.ADDR_W(ADDR_W), .WAIT(0)) u0 (
      .clk(clk), .rst(rst), .romCe(romCe0), .pc(pc0),
      .ldWe(ldWe), .ldAddr(ldAddr), .ldData(ldData),
      .inst(inst0), .instValid(valid0), .busy(busy0),
      .rangeErr(rerr0), .alignErr(aerr0));

   inst_rom_ctrl #(.ADDR_W(ADDR_W), .WAIT(3)) u3 (
      .clk(clk), .rst(rst), .romCe(romCe3), .pc(pc3),
      .ldWe(ldWe), .ldAddr(ldAddr), .ldData(ldData),
      .inst(inst3), .instValid(valid3), .busy(busy3),
      .rangeErr(rerr3), .alignErr(aerr3));

   inst_rom_ctrl #(.ADDR_W(ADDR_W), .WAIT(2)) u2 (
      .clk(clk), .rst(rst), .romCe(romCe2), .pc(pc2),
      .ldWe(ldWe), .ldAddr(ldAddr), .ldData(ldData),
      .inst(inst2), .instValid(valid2), .busy(busy2),
      .rangeErr(rerr2), .alignErr(aerr2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; ldWe = 1'b0; ldAddr = '0; ldData = '0;
      romCe0 = 1'b0; romCe3 = 1'b0; romCe2 = 1'b0;
      pc0 = '0; pc3 = '0; pc2 = '0;
      tick(); tick();

      // Reset state
      check("rst_inst", inst0, 32'h0);
      check("rst_valid", {31'd0, valid0}, 32'd0);
      check("rst_busy", {31'd0, busy3}, 32'd0);
      check("rst_errs", {30'd0, rerr0, aerr0}, 32'd0);

      rst = 1'b1;
      // Load words 0..3 with 1..4 and word 7 with 0x77
      for (int i = 0; i < 4; i++) begin
         ldWe = 1'b1; ldAddr = ADDR_W'(i); ldData = 32'(i + 1);
         tick();
      end
      ldAddr = ADDR_W'(7); ldData = 32'h77;
      tick();
      ldWe = 1'b0;

      // WAIT=0 back-to-back fetches, one per cycle
      for (int i = 0; i < 4; i++) begin
         romCe0 = 1'b1; pc0 = 32'(4 * i);
         tick();
         check($sformatf("b2b_valid%0d", i), {31'd0, valid0}, 32'd1);
         check($sformatf("b2b_inst%0d", i), inst0, 32'(i + 1));
      end
      romCe0 = 1'b0;
      tick();
      check("b2b_end_valid", {31'd0, valid0}, 32'd0);
      check("b2b_hold_inst", inst0, 32'd4);

      // WAIT=3, pc changes during wait
      ldWe = 1'b1; ldAddr = ADDR_W'(1); ldData = 32'hDEADBEEF;
      tick();
      ldWe = 1'b0;
      romCe3 = 1'b1; pc3 = 32'd4;
      tick();
      check("w3_c1", {30'd0, busy3, valid3}, 32'b10);
      pc3 = 32'd8;
      tick();
      check("w3_c2", {30'd0, busy3, valid3}, 32'b10);
      tick();
      check("w3_c3", {30'd0, busy3, valid3}, 32'b10);
      tick();
      check("w3_c4", {30'd0, busy3, valid3}, 32'b01);
      check("w3_inst", inst3, 32'hDEADBEEF);
      romCe3 = 1'b0;
      tick();
      check("w3_after", {30'd0, busy3, valid3}, 32'b00);

      // WAIT=2, cancel one cycle after acceptance
      romCe2 = 1'b1; pc2 = 32'd0;
      tick();
      check("w2_busy", {30'd0, busy2, valid2}, 32'b10);
      romCe2 = 1'b0;
      tick();
      check("w2_cancel", {30'd0, busy2, valid2}, 32'b00);
      tick(); tick();
      check("w2_no_resp", {30'd0, busy2, valid2}, 32'b00);
      // Back in IDLE: a fresh request responds with latency 3
      romCe2 = 1'b1; pc2 = 32'd8;
      tick(); tick();
      check("w2_new_wait", {30'd0, busy2, valid2}, 32'b10);
      tick();
      check("w2_new_valid", {30'd0, busy2, valid2}, 32'b01);
      check("w2_new_inst", inst2, 32'd3);
      romCe2 = 1'b0;
      tick();

      // Same-edge write and read: write-first
      ldWe = 1'b1; ldAddr = ADDR_W'(5); ldData = 32'h12345678;
      romCe0 = 1'b1; pc0 = 32'd20;
      tick();
      ldWe = 1'b0;
      check("wf_valid", {31'd0, valid0}, 32'd1);
      check("wf_inst", inst0, 32'h12345678);
      tick();
      check("wf_stored", inst0, 32'h12345678);

      // Out of range, then pc[1:0]=2 back-to-back
      pc0 = 32'h1000;
      tick();
      check("oor_inst", inst0, 32'h0);
      check("oor_flags", {29'd0, valid0, rerr0, aerr0}, 32'b110);
      pc0 = 32'h2;
      tick();
`ifdef IROM_ALIGN_CHECK_EN
      check("mis_inst", inst0, 32'h0);
      check("mis_flags", {29'd0, valid0, rerr0, aerr0}, 32'b101);
`else
      check("mis_inst", inst0, 32'd1);
      check("mis_flags", {29'd0, valid0, rerr0, aerr0}, 32'b100);
`endif
      romCe0 = 1'b0;
      tick();
      check("flags_idle", {29'd0, valid0, rerr0, aerr0}, 32'b000);

      // Async reset mid-WAIT; loader write during reset must be ignored
      romCe3 = 1'b1; pc3 = 32'd0;
      tick();
      check("ar_busy", {31'd0, busy3}, 32'd1);
      #2;
      rst = 1'b0;
      ldWe = 1'b1; ldAddr = ADDR_W'(7); ldData = 32'h00000BAD;
      #1;
      check("ar_u3_outs", {busy3, valid3, rerr3, aerr3, 28'd0} | inst3, 32'h0);
      check("ar_u0_inst", inst0, 32'h0);
      tick(); tick();
      ldWe = 1'b0; romCe3 = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("ar_no_resp%0d", i), {30'd0, busy3, valid3}, 32'b00);
      end
      romCe0 = 1'b1; pc0 = 32'd28;
      tick();
      check("ar_ld_ignored", inst0, 32'h77);
      romCe0 = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_rom_ctrl.md
INST_ROM_CTRL -- requirements
Module: inst_rom_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT, default 1: extra read wait cycles, legal range 0..7.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port romCe  input  1  fetch request from the CPU fetch stage.
REQ-006 SHALL have port pc  input  32  byte address of the requested instruction.
REQ-007 SHALL have port ldWe  input  1  program-loader word write enable.
REQ-008 SHALL have port ldAddr  input  ADDR_W  program-loader word address.
REQ-009 SHALL have port ldData  input  32  program-loader write data.
REQ-010 SHALL have port inst  output  32  fetched instruction, registered.
REQ-011 SHALL have port instValid  output  1  inst holds the response to the accepted request, one cycle per response.
REQ-012 SHALL have port busy  output  1  request in wait; new requests are not accepted.
REQ-013 SHALL have port rangeErr  output  1  the response's word index was at or beyond 2^ADDR_W.
REQ-014 SHALL have port alignErr  output  1  the response's pc was misaligned; present only in the form described in REQ-033.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 SHALL accept a request on a rising edge where romCe=1 and the state is IDLE or RESP, and SHALL capture pc into an internal register on that edge.
REQ-017 SHALL compute the word index as captured pc[ADDR_W+1:2]; pc[31:ADDR_W+2] nonzero SHALL be out of range.
REQ-018 SHALL, with WAIT=0, go directly to RESP on acceptance; instValid=1 on the next cycle (latency 1).
REQ-019 SHALL, with WAIT=N>0, enter WAIT, load a down-counter with N and decrement it each cycle, then enter RESP when it reaches 1 (latency N+1); busy=1 throughout WAIT.
REQ-020 SHALL, in RESP, drive instValid=1 for exactly one cycle; if romCe=1 on that edge, accept back-to-back (WAIT=0 gives one fetch per cycle), otherwise return to IDLE.
REQ-021 SHALL ignore pc changes during WAIT because the captured address is used.
REQ-022 SHALL, if romCe drops to 0 during WAIT, cancel the request: return to IDLE, produce no instValid, clear busy on the next cycle.
REQ-023 SHALL read memory on the edge entering RESP; inst SHALL hold its last value while instValid=0.
REQ-024 SHALL perform a loader write (ldWe=1) on any cycle, independent of the fetch FSM.
REQ-025 SHALL resolve a write and a read of the same word on the same edge as write-first: the response returns ldData.
REQ-026 SHALL, on an out-of-range response, drive inst=32'h0 (NOP) and rangeErr=1; error flags are valid only with instValid and SHALL be 0 otherwise.
REQ-027 SHALL wrap ldAddr naturally within ADDR_W bits, since no out-of-range loader address exists.

Reset
REQ-028 SHALL, while rst=0, force state=IDLE, counter=0, inst=0, instValid=0, busy=0, rangeErr=0, alignErr=0.
REQ-029 SHALL, on reset asserted mid-WAIT or in RESP, drop the outstanding request with no response after release.
REQ-030 SHALL NOT reset memory contents; the loader writes are lost only by overwrite.
REQ-031 SHALL ignore ldWe while rst=0.

Configuration
REQ-032 SHALL use macro IROM_ALIGN_CHECK_EN to compile the misalignment check in or out.
REQ-033 SHALL, when IROM_ALIGN_CHECK_EN is defined, treat captured pc[1:0]!=0 as misaligned: inst=0, alignErr=1 with instValid, memory not read; alignErr and rangeErr may both be 1.
REQ-034 SHALL, when IROM_ALIGN_CHECK_EN is undefined, ignore pc[1:0] and tie alignErr to 0.

Verification
REQ-035 SHALL cover: WAIT=0, load word 0..3 with 1..4, romCe=1 with pc=0,4,8,12 on consecutive cycles -> instValid=1 four consecutive cycles, inst=1,2,3,4.
REQ-036 SHALL cover: WAIT=3, pc=4 (word1=32'hDEADBEEF), pc changed to 8 the next cycle -> busy=1 three cycles, instValid=1 on the 4th cycle after acceptance, inst=32'hDEADBEEF.
REQ-037 SHALL cover: WAIT=2, romCe dropped one cycle after acceptance -> no instValid, busy=0 two cycles after acceptance, state IDLE.
REQ-038 SHALL cover: WAIT=0, ldWe=1 ldAddr=5 ldData=32'h12345678 on the same edge a pc=20 request is accepted -> inst=32'h12345678.
REQ-039 SHALL cover: ADDR_W=10, pc=32'h1000 -> inst=0, rangeErr=1; with IROM_ALIGN_CHECK_EN, pc=32'h2 -> inst=0, alignErr=1; without it, pc=32'h2 -> word0 data, alignErr=0.
REQ-040 SHALL cover: rst=0 asserted mid-WAIT asynchronously -> all outputs 0 immediately, no instValid after release.
